uart_tx_serializer: RTL

//  Synthesizable UART transmitter. It is the DUT stage that drives the serial line sampled by
//  the slave agent BFM on uart_if.

---
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// Push-side handshake bundle for the UART transmitter: byte valid/ready with payload.
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: FIFO-buffered bytes serialized as start/data(LSB first)/parity/stop frames.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_serializer_if.slave         s_if,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        stop2,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_d, busy_d;
    logic                  push, pop, start_frame, bit_done;
    logic [DATA_WIDTH-1:0] head;

    assign s_if.s_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push         = s_if.s_valid && s_if.s_ready;
    assign head         = mem[rd_ptr_q];
    assign bit_done     = (baud_cnt_q == '0);
    assign fifo_count   = count_q;

    // FIFO storage; contents need no reset since occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_if.s_data;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        baud_cnt_d  = bit_done ? div_q : baud_cnt_q - DIV_WIDTH'(1);
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        stop_cnt_d  = stop_cnt_q;
        start_frame = 1'b0;
        pop         = 1'b0;
        tx_d        = 1'b1;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (count_q != '0) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame config is captured only here, so mid-frame input changes wait for the next pop
        if (start_frame) begin
            pop        = 1'b1;
            state_d    = START;
            shift_d    = head;
            div_d      = baud_div;
            baud_cnt_d = baud_div;
            par_en_d   = parity_en;
            par_bit_d  = (^head) ^ parity_odd;
            stop2_d    = stop2;
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    // State, FIFO bookkeeping and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_q   <= pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            count_q    <= count_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx         <= tx_d;
            busy       <= busy_d;
        end
    end
endmodule
